// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial binary-to-BCD converter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_e;

    localparam int BCD_W       = 4;
    localparam int NDIG        = 3;
    localparam int DIGIT_OUT_W = 8;

    // Nibbles at or above this value get +3 before the next shift.
    localparam logic [BCD_W-1:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: adds 3 when the nibble is 5 or more.
// Latency: combinational.
// Backpressure: none.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] din,
    output logic [BCD_W-1:0] dout
);

    // Input is at most 9 here, so 4-bit arithmetic never carries out.
    assign dout = (din >= ADD3_THRESH) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_serial.sv
// Serial binary-to-BCD converter (shift-and-add-3), drives tens/units digits.
// Latency: WIDTH+1 cycles from accepted start to done pulse.
// Backpressure: none; start is ignored while busy, nothing is queued.
module bin2bcd_serial
    import bcd_pkg::*;
#(
    parameter int WIDTH = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [WIDTH-1:0]       bin,
    output logic                   busy,
    output logic                   done,
    output logic [DIGIT_OUT_W-1:0] D,
    output logic [DIGIT_OUT_W-1:0] U,
    output logic                   ovf
);

    localparam int CW    = $clog2(WIDTH + 1);
    localparam int SCR_W = BCD_W * NDIG;

    state_e             state;
    logic [WIDTH-1:0]   shift_reg;
    logic [SCR_W-1:0]   bcd;
    logic [CW-1:0]      cnt;
    logic [SCR_W-1:0]   bcd_adj;
    logic [SCR_W+WIDTH-1:0] cat_sh;

    // One correction unit per BCD digit of the scratch register.
    for (genvar g = 0; g < NDIG; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (bcd[g*BCD_W +: BCD_W]),
            .dout (bcd_adj[g*BCD_W +: BCD_W])
        );
    end

    // Corrected digits and remaining binary bits shifted left as one word.
    always_comb begin
        cat_sh = '0;
        cat_sh = {bcd_adj, shift_reg} << 1;
    end

    // Conversion FSM plus output digit registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            bcd       <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            D         <= '0;
            U         <= '0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_reg <= bin;
                        bcd       <= '0;
                        cnt       <= CW'(WIDTH);
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd       <= cat_sh[SCR_W+WIDTH-1:WIDTH];
                    shift_reg <= cat_sh[WIDTH-1:0];
                    cnt       <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    D     <= {{(DIGIT_OUT_W-BCD_W){1'b0}}, bcd[2*BCD_W-1:BCD_W]};
                    U     <= {{(DIGIT_OUT_W-BCD_W){1'b0}}, bcd[BCD_W-1:0]};
                    ovf   <= (bcd[3*BCD_W-1:2*BCD_W] != '0);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Directed bench for bin2bcd_serial with immediate-assertion checks.
// Latency: expects done WIDTH+1 = 8 edges after the accepted start edge.
// Backpressure: exercises ignored start while busy and back-to-back starts.
module tb_bin2bcd_serial;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [6:0] bin;
    logic       busy;
    logic       done;
    logic [7:0] D;
    logic [7:0] U;
    logic       ovf;

    int checks   = 0;
    int failures = 0;

    bin2bcd_serial #(.WIDTH(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .U     (U),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present a value with a one-edge start pulse (the accepted edge).
    task automatic start_conv(input logic [6:0] b);
        bin   = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Count edges until done is seen, bounded; a timeout is a failed check.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < 20);
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    int n;
    int pulses;

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        bin   = 7'd5;

        // Reset held two edges with start high: nothing begins.
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_D",    {24'd0, D},    32'd0);
        chk("rst_U",    {24'd0, U},    32'd0);
        chk("rst_ovf",  {31'd0, ovf},  32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // 42: busy for edges k..k+7, done only after k+8, outputs frozen meanwhile.
        start_conv(7'd42);
        bin = 7'd99;
        for (int i = 1; i <= 7; i++) begin
            chk("b42_busy", {31'd0, busy}, 32'd1);
            chk("b42_nodone", {31'd0, done}, 32'd0);
            chk("b42_D_hold", {24'd0, D}, 32'd0);
            tick();
        end
        chk("b42_busy_k7", {31'd0, busy}, 32'd1);
        tick();
        chk("b42_done", {31'd0, done}, 32'd1);
        chk("b42_busy_end", {31'd0, busy}, 32'd0);
        chk("b42_D", {24'd0, D}, 32'd4);
        chk("b42_U", {24'd0, U}, 32'd2);
        chk("b42_ovf", {31'd0, ovf}, 32'd0);
        tick();
        chk("b42_done_pulse", {31'd0, done}, 32'd0);
        chk("b42_D_hold2", {24'd0, D}, 32'd4);

        // Spot checks.
        start_conv(7'd99);  wait_done(n);
        chk("s99_lat", n, 32'd8);
        chk("s99_D", {24'd0, D}, 32'd9);
        chk("s99_U", {24'd0, U}, 32'd9);
        chk("s99_ovf", {31'd0, ovf}, 32'd0);
        start_conv(7'd100); wait_done(n);
        chk("s100_D", {24'd0, D}, 32'd0);
        chk("s100_U", {24'd0, U}, 32'd0);
        chk("s100_ovf", {31'd0, ovf}, 32'd1);
        start_conv(7'd127); wait_done(n);
        chk("s127_D", {24'd0, D}, 32'd2);
        chk("s127_U", {24'd0, U}, 32'd7);
        chk("s127_ovf", {31'd0, ovf}, 32'd1);

        // Full sweep 0..127.
        for (int b = 0; b < 128; b++) begin
            start_conv(7'(b));
            wait_done(n);
            chk("sweep_lat", n, 32'd8);
            chk("sweep_val", 32'(D) * 10 + 32'(U), 32'(b % 100));
            chk("sweep_ovf", {31'd0, ovf}, {31'd0, (b >= 100)});
        end
        tick();

        // Start while busy is ignored.
        start_conv(7'd63);
        tick();
        tick();
        bin   = 7'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) pulses++;
        end
        chk("busy_pulses", pulses, 32'd1);
        chk("busy_D", {24'd0, D}, 32'd6);
        chk("busy_U", {24'd0, U}, 32'd3);
        chk("busy_idle", {31'd0, busy}, 32'd0);

        // Reset mid-conversion aborts with no done pulse.
        start_conv(7'd88);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_D", {24'd0, D}, 32'd0);
        chk("abort_U", {24'd0, U}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) pulses++;
        end
        chk("abort_pulses", pulses, 32'd0);
        start_conv(7'd17);
        wait_done(n);
        chk("after_lat", n, 32'd8);
        chk("after_D", {24'd0, D}, 32'd1);
        chk("after_U", {24'd0, U}, 32'd7);

        // Back-to-back: second start in the done cycle.
        tick();
        start_conv(7'd12);
        wait_done(n);
        chk("bb1_D", {24'd0, D}, 32'd1);
        chk("bb1_U", {24'd0, U}, 32'd2);
        start_conv(7'd34);
        chk("bb_busy", {31'd0, busy}, 32'd1);
        chk("bb_D_hold", {24'd0, D}, 32'd1);
        wait_done(n);
        chk("bb_gap", n + 1, 32'd9);
        chk("bb2_D", {24'd0, D}, 32'd3);
        chk("bb2_U", {24'd0, U}, 32'd4);
        chk("bb2_ovf", {31'd0, ovf}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bin2bcd_serial.md
Name: bin2bcd_serial

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble). It is the producer side of the two-digit seven-segment decoder.
- Accepts a WIDTH-bit unsigned binary value on a start strobe.
- After a fixed latency, presents tens and units BCD digits on 8-bit buses that connect straight to the decoder's D and U inputs.
- Flags values of 100 or more via ovf.

Parameters:
- WIDTH, 7, binary input width; legal range 4..9. The internal scratch holds 3 BCD digits, max 999.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  conversion request; sampled only in IDLE
- bin  input  WIDTH  unsigned binary value; captured on the accepted start edge
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when D/U/ovf update
- D  output  8  tens digit, zero-extended 4-bit BCD (0..9)
- U  output  8  units digit, zero-extended 4-bit BCD (0..9)
- ovf  output  1  high when the last converted value was 100 or more

Behaviour:
- Reset: on any rising edge with rst_n=0:
  - state=IDLE; busy=0, done=0, D=8'd0, U=8'd0, ovf=0.
  - Scratch registers and counter are cleared.
  - Reset mid-conversion aborts it with no done pulse, and the decoder shows "00".
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - If start=1 at edge k: load shift_reg<=bin, bcd<=12'd0, cnt<=WIDTH, then go to SHIFT.
  - busy=1 from edge k.
- SHIFT, one bit per cycle:
  - Apply add-3 to each of the three BCD nibbles whose value is 5 or more.
  - Then shift {bcd,shift_reg} left by 1, so the MSB of shift_reg enters bcd[0].
  - Decrement cnt. When cnt reaches 1 (last shift), go to FINISH.
  - Exactly WIDTH shift edges: k+1 .. k+WIDTH.
- FINISH, at edge k+WIDTH+1:
  - D<={4'd0,bcd[7:4]}, U<={4'd0,bcd[3:0]}, ovf<=(bcd[11:8]!=0).
  - done<=1 for one cycle, busy<=0, state<=IDLE.
- Latency: start edge to done-high edge is WIDTH+1 cycles (8 for the default).
- Outputs D/U/ovf hold their values until the next FINISH. No intermediate values ever appear on D/U.
- start while busy (SHIFT/FINISH) is ignored; no queueing.
- start asserted in the cycle where done=1 is accepted, because state is already IDLE. This allows back-to-back conversions every WIDTH+2 cycles.
- bin changes after the accepted edge have no effect.
- Overflow: D/U always show value mod 100, e.g. 127 → D=2, U=7, ovf=1. ovf is registered alongside the digits.
- Nibble arithmetic is 4-bit. The add-3 correction never carries out of a nibble, because the input to it is 9 or less.

Decomposition:
- Shared package bcd_pkg:
  - state enum {IDLE, SHIFT, FINISH}
  - BCD_W=4, NDIG=3, DIGIT_OUT_W=8
  - localparam ADD3_THRESH=4'd5
- Sub-module bcd_add3: combinational, 4-bit in/4-bit out, adds 3 when the input is 5 or more. Instantiate three times.
- Counter width: $clog2(WIDTH+1).

Test Plan:
- Reset: hold rst_n=0 for 2 edges with start=1 → busy=0, done=0, D=0, U=0, ovf=0; no conversion starts.
- bin=42, start pulse at edge k → busy=1 for edges k..k+7; done=1 only after edge k+8; D=8'd4, U=8'd2, ovf=0.
- Sweep bin=0..127, one conversion each → D*10+U == bin mod 100; ovf==(bin>=100); spot checks 99→9,9,0; 100→0,0,1; 127→2,7,1.
- bin=63 started, then start=1 with bin=5 at edge k+3 → ignored; result D=6, U=3; exactly one done pulse.
- Start bin=88, then drive rst_n=0 at edge k+4 → no done pulse; D/U=0; busy=0. Next start with bin=17 → D=1, U=7 after 8 cycles.
- Back-to-back: bin=12, then start=1 with bin=34 in the done cycle → second done exactly 9 edges after the first; outputs go 1,2 then 3,4.
